psx_link_model: RTL and testbench

//  Self-contained PlayStation pad-bus model: console master (poll engine) plus digital-pad slave, wired by the
//  PSX serial bus (att, psx_clk, cmd, data, ack; all idle HIGH). Runs from one slow system clock (~7 kHz).

---
 rtl/psx_bus_pkg.sv | 43 ++++
 rtl/psx_pad_responder.sv | 111 +++++++++++
 rtl/psx_link_model.sv | 167 ++++++++++++++++
 tb/tb_psx_link_model.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/psx_bus_pkg.sv
// Shared definitions for the PlayStation pad-bus model: protocol byte values,
// byte positions within a poll frame, and the console and pad state encodings.
package psx_bus_pkg;

  localparam logic [7:0] PSX_CMD_START = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL  = 8'h42;
  localparam logic [7:0] PSX_CMD_IDLE  = 8'h00;
  localparam logic [7:0] PSX_MARKER    = 8'h5A;

  localparam logic [2:0] BYTE_START  = 3'd0;
  localparam logic [2:0] BYTE_ID     = 3'd1;
  localparam logic [2:0] BYTE_MARK   = 3'd2;
  localparam logic [2:0] BYTE_BTN_LO = 3'd3;
  localparam logic [2:0] BYTE_BTN_HI = 3'd4;
  localparam logic [2:0] BYTE_LAST   = BYTE_BTN_HI;

  typedef enum logic [2:0] {
    C_IDLE,
    C_SELECT,
    C_BIT_A,
    C_BIT_B,
    C_WAIT_ACK,
    C_DONE
  } console_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_BYTE,
    P_ACK_WAIT,
    P_ACK,
    P_IGNORE
  } pad_state_t;

  // Byte the console shifts out on cmd for each frame position.
  function automatic logic [7:0] console_cmd_byte(input logic [2:0] idx);
    case (idx)
      BYTE_START: return PSX_CMD_START;
      BYTE_ID:    return PSX_CMD_POLL;
      default:    return PSX_CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/psx_pad_responder.sv
// Digital-pad slave on the PSX serial bus.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   att, psx_clk, cmd  bus lines driven by the console
//   buttons[15:0]      active-low button state, latched when att falls
//   data               pad->console serial, LSB first, idle high
//   ack                active-low one-clock acknowledge after bytes 1-4
module psx_pad_responder #(
  parameter int          ACK_DELAY = 2,
  parameter logic [7:0]  PAD_ID    = 8'h41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack
);
  import psx_bus_pkg::*;

  pad_state_t  state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [3:0]  dly_cnt;
  logic        pclk_q;
  logic [6:0]  rx_sh;
  logic [15:0] btn_lat;
  logic        pclk_rise;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;

  // Sampling is edge-based so a psx_clk parked high between bytes is never
  // mistaken for fresh bits.
  assign pclk_rise = psx_clk & ~pclk_q;
  assign rx_byte   = {cmd, rx_sh};

  always_comb begin
    case (byte_idx)
      BYTE_START:  tx_byte = 8'hFF;
      BYTE_ID:     tx_byte = PAD_ID;
      BYTE_MARK:   tx_byte = PSX_MARKER;
      BYTE_BTN_LO: tx_byte = btn_lat[7:0];
      default:     tx_byte = btn_lat[15:8];
    endcase
  end

  always_comb begin
    state_nxt = state;
    data      = 1'b1;
    ack       = 1'b1;
    case (state)
      P_IDLE:     if (!att) state_nxt = P_BYTE;
      P_BYTE: begin
        data = tx_byte[bit_cnt];
        if (pclk_rise && bit_cnt == 3'd7) begin
          if ((byte_idx == BYTE_START && rx_byte != PSX_CMD_START) ||
              (byte_idx == BYTE_ID && rx_byte != PSX_CMD_POLL) ||
              byte_idx == BYTE_LAST)
            state_nxt = P_IGNORE;
          else
            state_nxt = P_ACK_WAIT;
        end
      end
      // One cycle of the delay is the B half-bit itself.
      P_ACK_WAIT: if (dly_cnt == 4'(ACK_DELAY - 2)) state_nxt = P_ACK;
      P_ACK: begin
        ack       = 1'b0;
        state_nxt = P_BYTE;
      end
      P_IGNORE:   state_nxt = P_IGNORE;
      default:    state_nxt = P_IDLE;
    endcase
    // att high always resynchronises the pad to the start of a frame.
    if (att) state_nxt = P_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= P_IDLE;
      pclk_q   <= 1'b1;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      dly_cnt  <= 4'd0;
    end else begin
      state  <= state_nxt;
      pclk_q <= psx_clk;
      if (att) begin
        bit_cnt  <= 3'd0;
        byte_idx <= 3'd0;
      end else begin
        case (state)
          P_BYTE: begin
            dly_cnt <= 4'd0;
            if (pclk_rise) bit_cnt <= bit_cnt + 3'd1;
          end
          P_ACK_WAIT: dly_cnt  <= dly_cnt + 4'd1;
          P_ACK:      byte_idx <= byte_idx + 3'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == P_BYTE && pclk_rise) rx_sh <= rx_byte[7:1];
    if (state == P_IDLE && !att) btn_lat <= buttons;
  end

endmodule

// File: rtl/psx_link_model.sv
// Loopback model of a PlayStation console poll engine and a digital pad.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   buttons[15:0]   active-low pad buttons fed to the pad model
//   att, psx_clk,   console-driven bus lines (idle high)
//   cmd
//   data, ack       pad-driven bus lines (idle high)
//   id_out[7:0]     ID byte of the last good frame
//   buttons_out     button bytes of the last good frame
//   frame_valid     one-clock pulse per good frame
//   frame_error     one-clock pulse on ack timeout or bad marker byte
module psx_link_model #(
  parameter int         POLL_GAP    = 20,
  parameter int         ACK_DELAY   = 2,
  parameter int         ACK_TIMEOUT = 8,
  parameter logic [7:0] PAD_ID      = 8'h41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] buttons,
  output logic        att,
  output logic        psx_clk,
  output logic        cmd,
  output logic        data,
  output logic        ack,
  output logic [7:0]  id_out,
  output logic [15:0] buttons_out,
  output logic        frame_valid,
  output logic        frame_error
);
  import psx_bus_pkg::*;

  console_state_t state, state_nxt;
  logic [15:0] gap_cnt;
  logic [3:0]  to_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [6:0]  rx_sh;
  logic [7:0]  id_r, mark_r, btn_lo_r, btn_hi_r;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic        pad_data;
  logic        pad_ack;

  psx_pad_responder #(
    .ACK_DELAY (ACK_DELAY),
    .PAD_ID    (PAD_ID)
  ) u_pad (
    .clk     (clk),
    .reset   (reset),
    .att     (att),
    .psx_clk (psx_clk),
    .cmd     (cmd),
    .buttons (buttons),
    .data    (pad_data),
    .ack     (pad_ack)
  );

  assign data    = pad_data;
  assign ack     = pad_ack;
  assign rx_byte = {pad_data, rx_sh};
  assign tx_byte = console_cmd_byte(byte_idx);

  always_comb begin
    state_nxt = state;
    att       = 1'b0;
    psx_clk   = 1'b1;
    cmd       = 1'b1;
    case (state)
      C_IDLE: begin
        att = 1'b1;
        if (gap_cnt == 16'(POLL_GAP - 1)) state_nxt = C_SELECT;
      end
      C_SELECT: state_nxt = C_BIT_A;
      C_BIT_A: begin
        psx_clk   = 1'b0;
        cmd       = tx_byte[bit_idx];
        state_nxt = C_BIT_B;
      end
      C_BIT_B: begin
        cmd = tx_byte[bit_idx];
        if (bit_idx == 3'd7)
          state_nxt = (byte_idx == BYTE_LAST) ? C_DONE : C_WAIT_ACK;
        else
          state_nxt = C_BIT_A;
      end
      C_WAIT_ACK: begin
        if (!pad_ack)
          state_nxt = C_BIT_A;
        else if (to_cnt == 4'(ACK_TIMEOUT - 1))
          state_nxt = C_IDLE;
      end
      C_DONE: begin
        att       = 1'b1;
        state_nxt = C_IDLE;
      end
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= C_IDLE;
      gap_cnt     <= 16'd0;
      to_cnt      <= 4'd0;
      bit_idx     <= 3'd0;
      byte_idx    <= 3'd0;
      id_out      <= 8'h00;
      buttons_out <= 16'hFFFF;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        C_IDLE: begin
          gap_cnt  <= gap_cnt + 16'd1;
          bit_idx  <= 3'd0;
          byte_idx <= 3'd0;
        end
        C_BIT_B: begin
          bit_idx <= bit_idx + 3'd1;
          to_cnt  <= 4'd0;
        end
        C_WAIT_ACK: begin
          to_cnt <= to_cnt + 4'd1;
          if (!pad_ack) begin
            byte_idx <= byte_idx + 3'd1;
          end else if (to_cnt == 4'(ACK_TIMEOUT - 1)) begin
            frame_error <= 1'b1;
            gap_cnt     <= 16'd0;
          end
        end
        C_DONE: begin
          // DONE already holds att high, so it counts toward the gap.
          gap_cnt <= 16'd1;
          if (mark_r == PSX_MARKER) begin
            id_out      <= id_r;
            buttons_out <= {btn_hi_r, btn_lo_r};
            frame_valid <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Receive shift and per-byte capture at each psx_clk-high sample point.
  always_ff @(posedge clk) begin
    if (state == C_BIT_B) begin
      rx_sh <= rx_byte[7:1];
      if (bit_idx == 3'd7) begin
        case (byte_idx)
          BYTE_ID:     id_r     <= rx_byte;
          BYTE_MARK:   mark_r   <= rx_byte;
          BYTE_BTN_LO: btn_lo_r <= rx_byte;
          BYTE_BTN_HI: btn_hi_r <= rx_byte;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psx_link_model.sv
module tb_psx_link_model;

  logic        clk;
  logic        reset;
  logic [15:0] buttons;
  logic        att, psx_clk, cmd, data, ack;
  logic [7:0]  id_out;
  logic [15:0] buttons_out;
  logic        frame_valid, frame_error;

  int errors = 0;
  int checks = 0;

  psx_link_model dut (
    .clk         (clk),
    .reset       (reset),
    .buttons     (buttons),
    .att         (att),
    .psx_clk     (psx_clk),
    .cmd         (cmd),
    .data        (data),
    .ack         (ack),
    .id_out      (id_out),
    .buttons_out (buttons_out),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: decodes bytes on cmd/data at psx_clk rises and
  // measures ack pulses; per-frame counters clear when att falls.
  int         cyc = 0;
  logic       prev_att = 1'b1, prev_pclk = 1'b1, prev_ack = 1'b1;
  logic [7:0] mon_data [8];
  logic [7:0] mon_cmd [8];
  logic [7:0] dsh = 8'h00, csh = 8'h00;
  logic [2:0] mon_byte = 3'd0, mon_bit = 3'd0;
  int         last_rise = 0;
  int         ack_cnt = 0, ack_long = 0, ack_bad = 0, fe_cnt = 0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_att  <= att;
    prev_pclk <= psx_clk;
    prev_ack  <= ack;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (prev_att && !att) begin
      mon_byte <= 3'd0;
      mon_bit  <= 3'd0;
      ack_cnt  <= 0;
      ack_long <= 0;
      ack_bad  <= 0;
    end else begin
      if (!prev_pclk && psx_clk && !att) begin
        last_rise <= cyc;
        dsh <= {data, dsh[7:1]};
        csh <= {cmd, csh[7:1]};
        if (mon_bit == 3'd7) begin
          mon_data[mon_byte] <= {data, dsh[7:1]};
          mon_cmd[mon_byte]  <= {cmd, csh[7:1]};
          mon_byte <= mon_byte + 3'd1;
        end
        mon_bit <= mon_bit + 3'd1;
      end
      if (!ack && prev_ack) begin
        ack_cnt <= ack_cnt + 1;
        if (cyc - last_rise != 2) ack_bad <= ack_bad + 1;
      end
      if (!ack && !prev_ack) ack_long <= ack_long + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fv(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fe(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_att"},     att,     1'b1);
    chk({tag, "_psx_clk"}, psx_clk, 1'b1);
    chk({tag, "_cmd"},     cmd,     1'b1);
    chk({tag, "_data"},    data,    1'b1);
    chk({tag, "_ack"},     ack,     1'b1);
  endtask

  initial begin
    logic ok;
    int   fe_seen_before;

    // Reset held for three clocks
    reset   = 1'b1;
    buttons = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk_bus_idle("rst");
    chk("rst_buttons_out", buttons_out, 16'hFFFF);
    chk("rst_id_out",      id_out,      8'h00);
    chk("rst_fv",          frame_valid, 1'b0);
    chk("rst_fe",          frame_error, 1'b0);
    reset = 1'b0;

    // Frame 1: no buttons pressed
    wait_fv(200, ok);
    chk("f1_valid_seen", ok, 1'b1);
    chk("f1_id_out",      id_out,      8'h41);
    chk("f1_buttons_out", buttons_out, 16'hFFFF);
    chk("f1_att_high",    att,         1'b1);
    chk("f1_nbytes",      mon_byte,    3'd5);
    chk("f1_cmd0",        mon_cmd[0],  8'h01);
    chk("f1_cmd1",        mon_cmd[1],  8'h42);
    chk("f1_cmd2",        mon_cmd[2],  8'h00);
    chk("f1_data0",       mon_data[0], 8'hFF);
    chk("f1_data1",       mon_data[1], 8'h41);
    chk("f1_data2",       mon_data[2], 8'h5A);
    chk("f1_ack_count",   ack_cnt,     4);
    chk("f1_ack_wide",    ack_long,    0);
    chk("f1_ack_delay",   ack_bad,     0);
    chk("f1_no_error",    fe_cnt,      0);
    @(negedge clk);
    chk("f1_fv_one_clk",  frame_valid, 1'b0);

    // Frame 2: A5F0, with buttons changing mid-frame (must not leak in)
    buttons = 16'hA5F0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!att) begin ok = 1'b1; break; end
    end
    chk("f2_att_fall", ok, 1'b1);
    repeat (4) @(negedge clk);
    buttons = 16'h1234;
    wait_fv(200, ok);
    chk("f2_valid_seen",  ok, 1'b1);
    chk("f2_data3",       mon_data[3], 8'hF0);
    chk("f2_data4",       mon_data[4], 8'hA5);
    chk("f2_buttons_out", buttons_out, 16'hA5F0);
    chk("f2_ack_count",   ack_cnt,     4);
    chk("f2_ack_delay",   ack_bad,     0);

    // Frame 3: pad ack stuck high -> timeout after byte 1
    force dut.pad_ack = 1'b1;
    fe_seen_before = fe_cnt;
    wait_fe(200, ok);
    chk("to_error_seen",   ok, 1'b1);
    chk("to_att_high",     att,         1'b1);
    chk("to_latency",      cyc - last_rise, 8 + 1);
    chk("to_nbytes",       mon_byte,    3'd1);
    chk("to_ack_count",    ack_cnt,     0);
    chk("to_buttons_hold", buttons_out, 16'hA5F0);
    chk("to_id_hold",      id_out,      8'h41);
    chk("to_no_valid",     frame_valid, 1'b0);
    chk("to_prior_errors", fe_seen_before, 0);
    release dut.pad_ack;

    // Frame 4: recovers after the timeout
    wait_fv(200, ok);
    chk("f4_valid_seen",  ok, 1'b1);
    chk("f4_buttons_out", buttons_out, 16'h1234);

    // Reset asserted in the middle of byte 3
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mon_byte == 3'd2 && mon_bit == 3'd3) begin ok = 1'b1; break; end
    end
    chk("mr_reached_byte3", ok, 1'b1);
    chk("mr_att_low", att, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_bus_idle("mr");
    @(negedge clk);
    reset = 1'b0;
    chk("mr_buttons_out", buttons_out, 16'hFFFF);
    chk("mr_id_out",      id_out,      8'h00);
    buttons = 16'h5AC3;
    wait_fv(200, ok);
    chk("mr_valid_seen",  ok, 1'b1);
    chk("mr_id_after",    id_out,      8'h41);
    chk("mr_buttons_after", buttons_out, 16'h5AC3);
    chk("mr_ack_count",   ack_cnt,     4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
